// File: rtl/conv_tx_core_param_if.sv
// conv_tx_core_param_if: frame control, input bit stream and coded output stream of the transmit core.
// CONV_TX_SCR_BYPASS_EN adds the scr_bypass control.
interface conv_tx_core_param_if #(
   parameter int LEN_W = 16,
   parameter int SCR_W = 7
);
   logic start, in_bit, in_valid, in_ready, out_bit, out_valid, out_ready, out_last, busy, frame_done;
   logic [LEN_W-1:0] frame_len;
   logic [SCR_W-1:0] seed;
   logic [1:0] rate_mode;
`ifdef CONV_TX_SCR_BYPASS_EN
   logic scr_bypass;
`endif
   modport master (
`ifdef CONV_TX_SCR_BYPASS_EN
      output scr_bypass,
`endif
      output start, frame_len, seed, rate_mode, in_bit, in_valid, out_ready,
      input in_ready, out_bit, out_valid, out_last, busy, frame_done
   );
   modport slave (
`ifdef CONV_TX_SCR_BYPASS_EN
      input scr_bypass,
`endif
      input start, frame_len, seed, rate_mode, in_bit, in_valid, out_ready,
      output in_ready, out_bit, out_valid, out_last, busy, frame_done
   );
endinterface

// File: rtl/conv_tx_core_param.sv
// conv_tx_core_param: scrambler -> rate-1/2 convolutional encoder -> puncturer with zero tail and 2-bit output serializer.
// Optional CONV_TX_SCR_BYPASS_EN adds a per-frame scrambler bypass.
module conv_tx_core_param #(
   parameter int K = 7,
   parameter logic [K-1:0] G0 = 7'b1011011,
   parameter logic [K-1:0] G1 = 7'b1111001,
   parameter int SCR_W = 7,
   parameter logic [1:SCR_W] SCR_TAPS = 7'b0001001,
   parameter int LEN_W = 16
) (
   input logic Clk,
   input logic reset,
   conv_tx_core_param_if.slave bus
);
   localparam int TW = $clog2(K - 1) > 0 ? $clog2(K - 1) : 1;
   typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
   state_t state;
   logic [1:SCR_W] s;
   logic [K-2:0] hist;
   logic [1:0] rate, phase, phase_nx, ser, ser_last, ser_cnt;
   logic [LEN_W-1:0] len, bit_cnt;
   logic [TW-1:0] tail_cnt;
   logic done, byp, fb, b, a_bit, b_bit, keep_a, keep_b, both, slot, step, pop, last_step;
`ifdef CONV_TX_SCR_BYPASS_EN
   always_ff @(posedge Clk)
      byp <= reset ? 1'b0 : (state == IDLE && bus.start) ? bus.scr_bypass : byp;
`else
   assign byp = 1'b0;
`endif
   always_comb begin
      fb = ^(s & SCR_TAPS);
      b = (state == DATA) & (bus.in_bit ^ (fb & ~byp));
      a_bit = ^({b, hist} & G0);
      b_bit = ^({b, hist} & G1);
      keep_a = phase != 2'd2;
      keep_b = phase != 2'd1;
      both = keep_a && keep_b;
      // a new step may load only when the serializer is empty or drains its last bit this cycle
      slot = ser_cnt == 2'd0 || (ser_cnt == 2'd1 && bus.out_ready);
      step = slot && (state == TAIL || (state == DATA && bus.in_valid));
      pop = ser_cnt != 2'd0 && bus.out_ready;
      last_step = state == TAIL && tail_cnt == TW'(K - 2);
      phase_nx = rate == 2'd1 ? {1'b0, ~phase[0]} : (rate == 2'd2 && phase != 2'd2) ? phase + 2'd1 : 2'd0;
   end
   assign bus.in_ready = state == DATA && slot;
   assign bus.out_valid = ser_cnt != 2'd0;
   assign bus.out_bit = ser[0];
   assign bus.out_last = ser_last[0];
   assign bus.busy = state != IDLE;
   assign bus.frame_done = done;
   always_ff @(posedge Clk) begin
      if (reset) begin
         state <= IDLE;
         s <= '0;
         hist <= '0;
         rate <= 2'd0;
         phase <= 2'd0;
         ser <= 2'd0;
         ser_last <= 2'd0;
         ser_cnt <= 2'd0;
         len <= '0;
         bit_cnt <= '0;
         tail_cnt <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (step) begin
            hist <= {b, hist[K-2:1]};
            phase <= phase_nx;
            ser <= {both ? b_bit : 1'b0, keep_a ? a_bit : b_bit};
            ser_last <= {both && last_step, !both && last_step};
            ser_cnt <= both ? 2'd2 : 2'd1;
         end else if (pop) begin
            ser <= {1'b0, ser[1]};
            ser_last <= {1'b0, ser_last[1]};
            ser_cnt <= ser_cnt - 2'd1;
         end
         case (state)
            IDLE: if (bus.start) begin
               state <= bus.frame_len == '0 ? TAIL : DATA;
               s <= bus.seed;
               hist <= '0;
               phase <= 2'd0;
               bit_cnt <= '0;
               tail_cnt <= '0;
               len <= bus.frame_len;
               rate <= bus.rate_mode == 2'd3 ? 2'd0 : bus.rate_mode;
            end
            DATA: if (step) begin
               s <= {fb, s[1:SCR_W-1]};
               bit_cnt <= bit_cnt + LEN_W'(1);
               if (bit_cnt == len - LEN_W'(1)) state <= TAIL;
            end
            TAIL: if (step) begin
               tail_cnt <= tail_cnt + TW'(1);
               if (last_step) state <= DRAIN;
            end
            DRAIN: if (pop && ser_cnt == 2'd1) begin
               state <= IDLE;
               done <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_tx_core_param.sv
// tb_conv_tx_core_param: scoreboard bench for the transmit core with an independent scrambler/encoder/puncture model.
module tb_conv_tx_core_param;
   logic Clk = 1'b0, reset = 1'b1;
   always #5 Clk = ~Clk;
   conv_tx_core_param_if bus ();
   conv_tx_core_param dut (.Clk(Clk), .reset(reset), .bus(bus.slave));
   bit din[$], exp_q[$], obs_q[$], obs_last[$];
   bit byp_sel = 1'b0, timed_out;
   int n_cmp = 0, n_fail = 0, unstable, last_pop, done_cyc, busy_done;

   // 802.11-style reference: x^7+x^4+1 scrambler, 133/171 encoder, puncture tables per rate
   function automatic void model(input logic [6:0] sd, input logic [1:0] rm, input int len, input bit byp);
      bit x[1:7];
      bit d[0:6];
      bit fb, v, a, b;
      int ph = 0, per;
      for (int i = 1; i <= 7; i++) x[i] = sd[7-i];
      for (int i = 0; i < 7; i++) d[i] = 1'b0;
      per = rm == 2'd1 ? 2 : rm == 2'd2 ? 3 : 1;
      for (int st = 0; st < len + 6; st++) begin
         v = 1'b0;
         if (st < len) begin
            fb = x[4] ^ x[7];
            v = din[st] ^ (fb & !byp);
            for (int j = 7; j > 1; j--) x[j] = x[j-1];
            x[1] = fb;
         end
         for (int j = 6; j > 0; j--) d[j] = d[j-1];
         d[0] = v;
         a = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
         b = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[6];
         if (ph != 2) exp_q.push_back(a);
         if (ph != 1) exp_q.push_back(b);
         ph = (ph + 1) % per;
      end
   endfunction

   task automatic run_frame(input logic [6:0] sd, input logic [1:0] rm, input int len, input bit rr, input int stop_at);
      int idx = 0, cyc = 0;
      bit hold = 0, hb = 0, hl = 0;
      obs_q.delete();
      obs_last.delete();
      unstable = 0; last_pop = -1; done_cyc = -1; busy_done = 1; timed_out = 0;
      @(negedge Clk);
      bus.seed = sd; bus.rate_mode = rm; bus.frame_len = 16'(len); bus.start = 1'b1;
`ifdef CONV_TX_SCR_BYPASS_EN
      bus.scr_bypass = byp_sel;
`endif
      @(negedge Clk);
      bus.start = 1'b0;
      forever begin
         bus.out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_valid = idx < len;
         bus.in_bit = idx < len ? din[idx] : 1'b0;
         #1;
         if (hold && (!bus.out_valid || bus.out_bit !== hb || bus.out_last !== hl)) unstable++;
         hold = bus.out_valid && !bus.out_ready; hb = bus.out_bit; hl = bus.out_last;
         if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back(bus.out_bit);
            obs_last.push_back(bus.out_last);
            last_pop = cyc;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.frame_done) begin done_cyc = cyc; busy_done = int'(bus.busy); end
         if (bus.frame_done || (stop_at > 0 && idx == stop_at)) break;
         if (cyc == 5000) begin timed_out = 1; break; end
         @(negedge Clk);
         cyc++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge Clk);
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.frame_done} !== 6'b0) begin
         n_fail++; $display("FAIL reset_outputs got %b want 000000", {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.frame_done});
      end
      @(negedge Clk);
      reset = 1'b0; bus.in_valid = 1'b1;
      @(negedge Clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_in_ready got ready=%b busy=%b want 0 0", bus.in_ready, bus.busy);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_scramble_zero;
      int nb = 1;
`ifdef CONV_TX_SCR_BYPASS_EN
      nb = 2;
`endif
      for (int p = 0; p < nb; p++) begin
         byp_sel = p[0];
         din.delete();
         repeat (8) din.push_back(1'b0);
         exp_q.delete();
         model(7'h7F, 2'd0, 8, byp_sel);
         run_frame(7'h7F, 2'd0, 8, 1'b0, 0);
         for (int i = 0; i < obs_q.size() && i < (byp_sel ? 28 : 8); i++) begin
            n_cmp++;
            if (obs_q[i] !== 1'b0) begin n_fail++; $display("FAIL zero_head bit%0d got %b want 0", i, obs_q[i]); end
         end
         n_cmp++;
         if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL zero_count got %0d want %0d", obs_q.size(), exp_q.size()); end
         while (exp_q.size() != 0 && obs_q.size() != 0) begin
            bit e, o, ol;
            e = exp_q.pop_front(); o = obs_q.pop_front(); ol = obs_last.pop_front();
            n_cmp++;
            if (o !== e || ol !== (exp_q.size() == 0)) begin
               n_fail++; $display("FAIL zero_stream got bit=%b last=%b want bit=%b last=%b", o, ol, e, exp_q.size() == 0);
            end
         end
         n_cmp++;
         if (timed_out || done_cyc != last_pop + 1 || busy_done != 0) begin
            n_fail++; $display("FAIL zero_done got done_cyc=%0d busy=%0d want %0d 0", done_cyc, busy_done, last_pop + 1);
         end
      end
      byp_sel = 1'b0;
   endtask

   task automatic test_impulse;
      logic [13:0] v;
      int n;
      logic [1:0] rm;
      for (int r = 0; r < 4; r++) begin
         rm = r == 1 ? 2'd2 : r == 2 ? 2'd1 : r == 3 ? 2'd3 : 2'd0;
         v = r == 1 ? 14'b00_1101110011 : r == 2 ? 14'b000_11011100111 : 14'b11011111001011;
         n = r == 1 ? 10 : r == 2 ? 11 : 14;
         exp_q.delete();
         for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
         din.delete();
         din.push_back(1'b1);
         run_frame(7'h00, rm, 1, 1'b0, 0);
         n_cmp++;
         if (obs_q.size() !== n) begin n_fail++; $display("FAIL impulse_count rate%0d got %0d want %0d", rm, obs_q.size(), n); end
         while (exp_q.size() != 0 && obs_q.size() != 0) begin
            bit e, o, ol;
            e = exp_q.pop_front(); o = obs_q.pop_front(); ol = obs_last.pop_front();
            n_cmp++;
            if (o !== e || ol !== (exp_q.size() == 0)) begin
               n_fail++; $display("FAIL impulse rate%0d got bit=%b last=%b want bit=%b last=%b", rm, o, ol, e, exp_q.size() == 0);
            end
         end
         n_cmp++;
         if (timed_out || done_cyc != last_pop + 1 || busy_done != 0) begin
            n_fail++; $display("FAIL impulse_done rate%0d got done_cyc=%0d busy=%0d want %0d 0", rm, done_cyc, busy_done, last_pop + 1);
         end
      end
   endtask

   task automatic test_backpressure;
      din.delete();
      for (int i = 0; i < 200; i++) din.push_back(1'($urandom_range(0, 1)));
      for (int p = 0; p < 2; p++) begin
         exp_q.delete();
         model(7'h4B, 2'd1, 200, 1'b0);
         run_frame(7'h4B, 2'd1, 200, p == 0, 0);
         n_cmp++;
         if (unstable != 0) begin n_fail++; $display("FAIL bp_stable pass%0d got %0d changes want 0", p, unstable); end
         n_cmp++;
         if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count pass%0d got %0d want %0d", p, obs_q.size(), exp_q.size()); end
         while (exp_q.size() != 0 && obs_q.size() != 0) begin
            bit e, o, ol;
            e = exp_q.pop_front(); o = obs_q.pop_front(); ol = obs_last.pop_front();
            n_cmp++;
            if (o !== e || ol !== (exp_q.size() == 0)) begin
               n_fail++; $display("FAIL bp_stream pass%0d got bit=%b last=%b want bit=%b last=%b", p, o, ol, e, exp_q.size() == 0);
            end
         end
         n_cmp++;
         if (timed_out || done_cyc != last_pop + 1 || busy_done != 0) begin
            n_fail++; $display("FAIL bp_done pass%0d got done_cyc=%0d busy=%0d want %0d 0", p, done_cyc, busy_done, last_pop + 1);
         end
      end
   endtask

   task automatic test_reset_mid;
      din.delete();
      for (int i = 0; i < 20; i++) din.push_back(1'($urandom_range(0, 1)));
      run_frame(7'h35, 2'd2, 20, 1'b0, 5);
      @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.frame_done} !== 6'b0) begin
         n_fail++; $display("FAIL midreset_outputs got %b want 000000", {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.frame_done});
      end
      reset = 1'b0;
      exp_q.delete();
      model(7'h35, 2'd2, 20, 1'b0);
      run_frame(7'h35, 2'd2, 20, 1'b0, 0);
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         bit e, o, ol;
         e = exp_q.pop_front(); o = obs_q.pop_front(); ol = obs_last.pop_front();
         n_cmp++;
         if (o !== e || ol !== (exp_q.size() == 0)) begin
            n_fail++; $display("FAIL midreset_stream got bit=%b last=%b want bit=%b last=%b", o, ol, e, exp_q.size() == 0);
         end
      end
      n_cmp++;
      if (timed_out || done_cyc != last_pop + 1 || busy_done != 0) begin
         n_fail++; $display("FAIL midreset_done got done_cyc=%0d busy=%0d want %0d 0", done_cyc, busy_done, last_pop + 1);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
      bus.frame_len = '0; bus.seed = '0; bus.rate_mode = 2'd0;
`ifdef CONV_TX_SCR_BYPASS_EN
      bus.scr_bypass = 1'b0;
`endif
      test_reset;
      test_scramble_zero;
      test_impulse;
      test_backpressure;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
